// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg
//   Shared definitions for the banked memory wrapper: controller state
//   encoding, statistics counter width and a width helper for deriving
//   address widths from sizes.
package banked_mem_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RESP
    } state_t;

    // Bits needed to index n entries (at least 1).
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/banked_mem_if.sv
// banked_mem_if
//   Request/response bus between the bus-side master and the banked memory.
//   Ports (signals):
//     valid/ready    request handshake, accepted when both are 1
//     wr_rd          1 = write, 0 = read
//     bcast          with a write, store wdata at the same word in all banks
//     addr           {bank, word}
//     wdata          write data
//     rdata/rvalid   read response, held until rready
//     rready         response consumed when rvalid && rready
interface banked_mem_if #(
    parameter int unsigned ADDR_SIZE = 9,
    parameter int unsigned WIDTH     = 8
) ();

    logic                 valid;
    logic                 ready;
    logic                 wr_rd;
    logic                 bcast;
    logic [ADDR_SIZE-1:0] addr;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     rdata;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output valid, wr_rd, bcast, addr, wdata, rready,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  valid, wr_rd, bcast, addr, wdata, rready,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/mem_bank.sv
// mem_bank
//   One DEPTH x WIDTH storage bank: synchronous write, registered read.
//   The array has no reset; the wrapper clears it after reset.
//   Ports:
//     clk    clock
//     we     write enable
//     waddr  write word address
//     raddr  read word address (registered every cycle)
//     wdata  write data
//     rdata  registered read data
module mem_bank
    import banked_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = width_of(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/banked_mem_wrapper.sv
// banked_mem_wrapper
//   Single valid/ready request port in front of NUM_BANKS memory banks.
//   Upper address bits select the bank, lower bits the word. After reset the
//   banks are zero-filled one word per cycle (INIT); writes may broadcast to
//   all banks; read responses are held until rready.
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     bus        request/response bus (slave side)
//     init_done  high once zero-initialisation is complete
//     wr_count   accepted writes, saturating
//     rd_count   completed read responses, saturating
module banked_mem_wrapper
    import banked_mem_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BANK_AW   = 6,
    parameter int unsigned ADDR_SIZE = 9
) (
    input  logic             clk,
    input  logic             rst,
    banked_mem_if.slave      bus,
    output logic             init_done,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    localparam int unsigned BSEL_W = ADDR_SIZE - BANK_AW;

    state_t state, state_next;

    logic [BANK_AW-1:0] init_ptr;
    logic [BANK_AW-1:0] rd_word;
    logic [BSEL_W-1:0]  rd_bank;
    logic [WIDTH-1:0]   rdata_hold;

    logic [BSEL_W-1:0]  req_bank;
    logic [BANK_AW-1:0] req_word;
    logic               wr_fire;
    logic               rd_fire;
    logic               resp_fire;

    logic [NUM_BANKS-1:0] bank_we;
    logic [BANK_AW-1:0]   bank_waddr;
    logic [BANK_AW-1:0]   bank_raddr;
    logic [WIDTH-1:0]     bank_wdata;
    logic [WIDTH-1:0]     bank_rdata [NUM_BANKS];

    assign req_bank = bus.addr[ADDR_SIZE-1:BANK_AW];
    assign req_word = bus.addr[BANK_AW-1:0];

    assign bus.ready  = (state == IDLE);
    assign bus.rvalid = (state == RESP);

    assign wr_fire   = bus.valid && bus.ready && bus.wr_rd;
    assign rd_fire   = bus.valid && bus.ready && !bus.wr_rd;
    assign resp_fire = bus.rvalid && bus.rready;

    // The bank read registers keep showing the latched word throughout RESP
    // (nothing writes the banks there), so the live bank output is the
    // response; once consumed, the captured copy keeps rdata stable.
    assign bus.rdata = bus.rvalid ? bank_rdata[rd_bank] : rdata_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            INIT:    if (init_ptr == BANK_AW'(DEPTH - 1)) state_next = IDLE;
            IDLE:    if (rd_fire)                         state_next = RESP;
            RESP:    if (resp_fire)                       state_next = IDLE;
            default:                                      state_next = INIT;
        endcase
    end

    always_comb begin
        bank_we    = '0;
        bank_waddr = req_word;
        bank_wdata = bus.wdata;
        bank_raddr = (state == IDLE) ? req_word : rd_word;
        if (state == INIT) begin
            bank_we    = '1;
            bank_waddr = init_ptr;
            bank_wdata = '0;
        end else if (wr_fire) begin
            if (bus.bcast) bank_we = '1;
            else           bank_we[req_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_ptr   <= '0;
            init_done  <= 1'b0;
            rd_word    <= '0;
            rd_bank    <= '0;
            rdata_hold <= '0;
            wr_count   <= '0;
            rd_count   <= '0;
        end else begin
            if (state == INIT) begin
                init_ptr <= init_ptr + 1'b1;
                if (state_next == IDLE) init_done <= 1'b1;
            end
            if (rd_fire) begin
                rd_word <= req_word;
                rd_bank <= req_bank;
            end
            if (resp_fire) rdata_hold <= bank_rdata[rd_bank];
            if (wr_fire && (wr_count != '1)) wr_count <= wr_count + 1'b1;
            if (resp_fire && (rd_count != '1)) rd_count <= rd_count + 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .AW    (BANK_AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bank_waddr),
            .raddr (bank_raddr),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_banked_mem_wrapper.sv
// tb_banked_mem_wrapper
//   Directed, table-driven bench for banked_mem_wrapper with default
//   parameters, plus hand-written sequences for init timing, backpressure,
//   reset during a response and counter saturation.
module tb_banked_mem_wrapper;
    import banked_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_wr = 0;
    int unsigned exp_rd = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic       wr;
        logic       bc;
        logic [8:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    banked_mem_if #(.ADDR_SIZE(9), .WIDTH(8)) bus ();

    banked_mem_wrapper #(
        .NUM_BANKS (8),
        .DEPTH     (64),
        .WIDTH     (8),
        .BANK_AW   (6),
        .ADDR_SIZE (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .wr_count  (wr_count),
        .rd_count  (rd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge after acceptance.
    task automatic req(input logic w, input logic b, input logic [8:0] a, input logic [7:0] d);
        int unsigned n;
        bus.valid = 1'b1;
        bus.wr_rd = w;
        bus.bcast = b;
        bus.addr  = a;
        bus.wdata = d;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: ready not seen after %0d cycles, expected 1", n);
        end
        @(negedge clk);
        bus.valid = 1'b0;
        if (w && exp_wr < 32'hFFFF) exp_wr++;
    endtask

    task automatic do_read(input string name, input logic b, input logic [8:0] a, input logic [7:0] exp);
        req(1'b0, b, a, 8'h00);
        check({name, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        check({name, "_rdata"}, 32'(bus.rdata), 32'(exp));
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        if (exp_rd < 32'hFFFF) exp_rd++;
        check({name, "_rvalid_clr"}, 32'(bus.rvalid), 32'd0);
        check({name, "_rdata_hold"}, 32'(bus.rdata), 32'(exp));
        check({name, "_rd_count"}, 32'(rd_count), exp_rd);
    endtask

    // Called at the negedge where rst has just been released.
    task automatic wait_init(input string name);
        int unsigned n;
        int unsigned early;
        n = 0;
        early = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            if (init_done !== 1'b0) early++;
            @(negedge clk);
            n++;
        end
        check({name, "_cycles"}, n, 32'd64);
        check({name, "_done_early"}, early, 32'd0);
        check({name, "_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        int unsigned c0;

        bus.valid  = 1'b0;
        bus.wr_rd  = 1'b0;
        bus.bcast  = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.rready = 1'b0;
        rst        = 1'b1;

        vecs.push_back(vec_t'{1'b1, 1'b0, 9'h0C5, 8'hA7});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h0C5, 8'hA7});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h045, 8'h00});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h006, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h046, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h086, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h0C6, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h106, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h146, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h186, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h1C6, 8'h3C});
        vecs.push_back(vec_t'{1'b1, 1'b0, 9'h1FF, 8'h55});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h1FF, 8'h55});
        vecs.push_back(vec_t'{1'b1, 1'b0, 9'h000, 8'h81});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h000, 8'h81});
        vecs.push_back(vec_t'{1'b1, 1'b0, 9'h146, 8'hE2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h146, 8'hE2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 9'h106, 8'h3C});
        vecs.push_back(vec_t'{1'b0, 1'b1, 9'h0C5, 8'hA7});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        rst = 1'b0;
        wait_init("init1");
        do_read("rd_after_init", 1'b0, 9'h123, 8'h00);

        // Broadcast to word 6; bank field of the address is ignored
        req(1'b1, 1'b1, 9'h146, 8'h3C);
        check("bcast_wr_count", 32'(wr_count), 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) req(1'b1, vecs[i].bc, vecs[i].addr, vecs[i].data);
            else do_read($sformatf("vec%0d", i), vecs[i].bc, vecs[i].addr, vecs[i].data);
        end
        check("vec_wr_count", 32'(wr_count), exp_wr);

        // Throughput: writes 1/cycle, reads 1 per 2 cycles
        c0 = cyc;
        for (int unsigned k = 0; k < 4; k++) req(1'b1, 1'b0, 9'(32'h0F0 + k), 8'(k));
        check("wr_b2b_cycles", cyc - c0, 32'd4);
        c0 = cyc;
        for (int unsigned k = 0; k < 3; k++) do_read($sformatf("tp%0d", k), 1'b0, 9'(32'h0F0 + k), 8'(k));
        check("rd_b2b_cycles", cyc - c0, 32'd6);

        // Backpressure: response held while rready=0
        req(1'b0, 1'b0, 9'h0C5, 8'h00);
        for (int unsigned k = 0; k < 5; k++) begin
            check("stall_rvalid", 32'(bus.rvalid), 32'd1);
            check("stall_rdata", 32'(bus.rdata), 32'hA7);
            check("stall_ready", 32'(bus.ready), 32'd0);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        exp_rd++;
        check("stall_ready_after", 32'(bus.ready), 32'd1);
        check("stall_rd_count", 32'(rd_count), exp_rd);

        // Asynchronous reset while a response is pending
        req(1'b0, 1'b0, 9'h1FF, 8'h00);
        check("resp_rvalid_pre_rst", 32'(bus.rvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("async_rst_rdata", 32'(bus.rdata), 32'd0);
        check("async_rst_ready", 32'(bus.ready), 32'd0);
        check("async_rst_init_done", 32'(init_done), 32'd0);
        check("async_rst_wr_count", 32'(wr_count), 32'd0);
        check("async_rst_rd_count", 32'(rd_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        wait_init("init2");
        do_read("cleared_0c5", 1'b0, 9'h0C5, 8'h00);
        do_read("cleared_1ff", 1'b0, 9'h1FF, 8'h00);
        do_read("cleared_146", 1'b0, 9'h146, 8'h00);

        // Write counter saturation
        for (int unsigned k = 0; k < 65534; k++) req(1'b1, 1'b0, 9'(k), 8'(k));
        check("wr_count_fffe", 32'(wr_count), 32'hFFFE);
        req(1'b1, 1'b0, 9'h010, 8'h11);
        check("wr_count_ffff", 32'(wr_count), 32'hFFFF);
        req(1'b1, 1'b1, 9'h011, 8'h22);
        req(1'b1, 1'b0, 9'h012, 8'h33);
        check("wr_count_sat", 32'(wr_count), 32'hFFFF);
        check("wr_count_model", 32'(wr_count), exp_wr);
        do_read("post_sat_read", 1'b0, 9'h111, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
